// File: rtl/div_signed_ctrl_if.sv
// rtl/div_signed_ctrl_if.sv - request, divider and result signals of the signed divide controller
interface div_signed_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic [WIDTH-1:0] in_numer;
   logic [WIDTH-1:0] in_denom;
   logic [WIDTH-1:0] div_numer;
   logic [WIDTH-1:0] div_denom;
   logic             div_clken;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remain;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_quotient;
   logic [WIDTH-1:0] out_remain;
   logic             out_div_zero;

   modport slave (
      input  in_valid, in_signed, in_numer, in_denom, div_quotient, div_remain, out_ready,
      output in_ready, div_numer, div_denom, div_clken, out_valid, out_quotient, out_remain,
             out_div_zero
   );

   modport master (
      output in_valid, in_signed, in_numer, in_denom, div_quotient, div_remain, out_ready,
      input  in_ready, div_numer, div_denom, div_clken, out_valid, out_quotient, out_remain,
             out_div_zero
   );
endinterface

// File: rtl/div_signed_ctrl.sv
// rtl/div_signed_ctrl.sv - issue/collect controller around the pipelined unsigned divider
module div_signed_ctrl #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = WIDTH + 1
) (
   input logic              clock,
   input logic              reset,
   div_signed_ctrl_if.slave bus
);
   logic             adv;
   logic             accept;
   logic             n_neg;
   logic             d_neg;
   logic [WIDTH-1:0] n_mag;
   logic [WIDTH-1:0] d_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Token pipe: stage 0 is loaded with the operands, stage LATENCY lines up with the divider output
   logic [LATENCY:0] tok_valid;
   logic [LATENCY:0] tok_qneg;
   logic [LATENCY:0] tok_rneg;
   logic [LATENCY:0] tok_dz;

   // The whole pipe, divider included, freezes only while a presented result is held off
   assign adv           = ~(bus.out_valid & ~bus.out_ready);
   assign bus.div_clken = adv;
   assign bus.in_ready  = adv & ~reset;
   assign accept        = bus.in_valid & bus.in_ready;

   // Operand magnitudes; unsigned requests pass through, |INT_MIN| stays 0x80..0 as an unsigned value
   always_comb begin
      n_neg = bus.in_signed & bus.in_numer[WIDTH-1];
      d_neg = bus.in_signed & bus.in_denom[WIDTH-1];
      n_mag = n_neg ? -bus.in_numer : bus.in_numer;
      d_mag = d_neg ? -bus.in_denom : bus.in_denom;
   end

   // Sign correction of the divider result; a zero divisor yields all-ones and the original dividend
   always_comb begin
      if (tok_dz[LATENCY]) begin
         q_fix = '1;
      end else begin
         q_fix = tok_qneg[LATENCY] ? -bus.div_quotient : bus.div_quotient;
      end
      r_fix = tok_rneg[LATENCY] ? -bus.div_remain : bus.div_remain;
   end

   // Operand registers, token pipe and output register all advance together
   always_ff @(posedge clock) begin
      if (reset) begin
         tok_valid        <= '0;
         tok_qneg         <= '0;
         tok_rneg         <= '0;
         tok_dz           <= '0;
         bus.div_numer    <= '0;
         bus.div_denom    <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_quotient <= '0;
         bus.out_remain   <= '0;
         bus.out_div_zero <= 1'b0;
      end else if (adv) begin
         tok_valid <= {tok_valid[LATENCY-1:0], accept};
         tok_qneg  <= {tok_qneg[LATENCY-1:0], accept & (n_neg ^ d_neg)};
         tok_rneg  <= {tok_rneg[LATENCY-1:0], accept & n_neg};
         tok_dz    <= {tok_dz[LATENCY-1:0], accept & (bus.in_denom == '0)};
         if (accept) begin
            bus.div_numer <= n_mag;
            bus.div_denom <= d_mag;
         end
         bus.out_valid    <= tok_valid[LATENCY];
         bus.out_quotient <= q_fix;
         bus.out_remain   <= r_fix;
         bus.out_div_zero <= tok_valid[LATENCY] & tok_dz[LATENCY];
      end
   end
endmodule

// File: doc/div_signed_ctrl.md
Name: div_signed_ctrl

Overview:
- Issue/collect controller wrapped around the pipelined non-restoring unsigned divider, `div_unsigned`.
- Accepts signed or unsigned division requests over a valid/ready handshake and converts operands to magnitudes.
- Drives the divider operand inputs and its clock enable, tracks in-flight requests with a token pipe, then sign-corrects quotient/remainder and presents them on a valid/ready output with full backpressure.
- Sits between the datapath issue logic and the divider.

Parameters:
- WIDTH, 32, operand width; must equal the divider's stages.
- LATENCY, 33, divider depth in clken-enabled cycles from operand change to quotient/remain valid (WIDTH+1).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_signed  input  1  1 = signed (two's complement) division, 0 = unsigned
- in_numer  input  WIDTH  dividend
- in_denom  input  WIDTH  divisor
- div_numer  output  WIDTH  registered magnitude dividend to divider
- div_denom  output  WIDTH  registered magnitude divisor to divider
- div_clken  output  1  divider clock enable
- div_quotient  input  WIDTH  divider quotient
- div_remain  input  WIDTH  divider remainder
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid & out_ready
- out_quotient  output  WIDTH  final quotient
- out_remain  output  WIDTH  final remainder
- out_div_zero  output  1  result came from a zero divisor

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Advance/stall:
  - adv = ~(out_valid & ~out_ready).
  - div_clken = adv and in_ready = adv & ~reset, both combinational.
  - When adv=0, every register in this block and in the divider holds.
- Stage 0 (on adv edge):
  - If in_valid & in_ready: load div_numer = |numer| and div_denom = |denom|. In signed mode, |x| = -x when x[WIDTH-1]=1, else x. In unsigned mode, operands pass unchanged.
  - Token[0] on a load: valid=1, qneg = signed & (n_msb ^ d_msb), rneg = signed & n_msb, dz = (denom==0).
  - If no accept: token[0].valid=0 and div_numer/div_denom hold their value.
- Token pipe:
  - Stages 0..LATENCY; shifts by one on each adv edge.
  - Token[LATENCY] is aligned with div_quotient/div_remain.
- Output register, loaded on adv edge from token[LATENCY]:
  - out_valid <= token[LATENCY].valid.
  - If dz: out_quotient = all ones, out_remain = div_remain with rneg applied. This equals the original numer, because the divider returns |numer| for a zero divisor.
  - Else: out_quotient = qneg ? -div_quotient : div_quotient, and out_remain = rneg ? -div_remain : div_remain, both truncated to WIDTH.
  - out_div_zero <= valid & dz.
  - When the loaded token is invalid, data outputs are don't-care; the bench checks them only when out_valid=1.
- Latency and throughput:
  - Accept in cycle c gives out_valid=1 in cycle c+LATENCY+2, with no stalls.
  - Throughput is one result per cycle.
  - A stall of k cycles adds exactly k cycles of latency. No request is lost or duplicated.
- Arithmetic rules:
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case INT_MIN / -1 (signed): quotient wraps to INT_MIN (0x80000000), remainder 0, out_div_zero=0.
  - |INT_MIN| = 0x80000000 is a valid unsigned magnitude.
- Simultaneous events:
  - Accept and output handshake in the same cycle are both honoured.
  - out_valid held with out_ready=0 blocks input acceptance.
- Reset values (sync): all token valid bits 0, out_valid 0, out_quotient/out_remain/out_div_zero 0, div_numer/div_denom 0.
- Reset mid-operation: all in-flight requests are discarded. The divider has no reset; its stale contents are never presented because no valid tokens remain. The first post-reset accept behaves as from idle.
- Reset-cycle handshake: in_ready=0 during the reset cycle, and div_clken follows adv.

Test Plan:
- Unsigned 100/7 -> after 35 cycles, out_quotient=14, out_remain=2, out_div_zero=0.
- Signed -7/2 -> quotient 0xFFFFFFFD (-3), remain 0xFFFFFFFF (-1); signed 7/-2 -> -3, 1.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remain 0; unsigned same operands -> quotient 0, remain 0x80000000.
- Divide by zero, signed -5/0 -> quotient 0xFFFFFFFF, remain 0xFFFFFFFB, out_div_zero=1.
- Back-to-back 40 random requests, then out_ready=0 for 10 cycles mid-stream:
  - in_ready=0 throughout the stall.
  - All 40 results arrive in order and match a reference model.
  - No gaps while out_ready=1.
- Assert reset 10 cycles after issuing 5 requests -> out_valid stays 0 for LATENCY+2 cycles with no new input. A new request 9/3 then returns 3, 0.
